// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control path
package mips_ctrl_pkg;

  // Control FSM states; the encoding is also exported on state_dbg.
  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_FETCH      = 4'd1,
    S_DECODE     = 4'd2,
    S_MEM_ADDR   = 4'd3,
    S_MEM_READ   = 4'd4,
    S_WRITE_BACK = 4'd5,
    S_MEM_WRITE  = 4'd6,
    S_EXECUTE    = 4'd7,
    S_R_COMPLETE = 4'd8,
    S_BRANCH     = 4'd9,
    S_JUMP       = 4'd10
  } state_t;

  // Opcode field (instruction bits 31:26).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation class handed to the ALU control unit.
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU B operand select.
  localparam logic [1:0] SRCB_REG      = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

  // PC source select.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Full set of datapath controls produced each cycle.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_timeout;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - opcode/memory handshake in, datapath controls out
interface multicycle_control_fsm_if;

  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic       mem_timeout;
  logic [3:0] state_dbg;

  // Control FSM side.
  modport master (
    input  op, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, mem_timeout, state_dbg
  );

  // Datapath side.
  modport slave (
    output op, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, mem_timeout, state_dbg
  );

endinterface

// File: rtl/multicycle_ctrl_decode.sv
// rtl/multicycle_ctrl_decode.sv - combinational state/handshake to control decode
module multicycle_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic [5:0] op,
  input  logic       timeout,
  output ctrl_t      ctrl
);

  // Moore controls per state, with FETCH load enables qualified by mem_ready.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut while the opcode is decoded.
        ctrl.alu_src_b  = SRCB_IMM_SHL2;
        ctrl.alu_op     = ALU_OP_ADD;
        ctrl.illegal_op = !op_supported(op);
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_WRITE_BACK: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_R_COMPLETE: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
    // An expired memory wait withdraws every request and only flags the abort.
    if (timeout) begin
      ctrl             = '0;
      ctrl.mem_timeout = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle MIPS control FSM with memory wait timeout
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 8
) (
  input logic                     clk,
  input logic                     rst_n,
  multicycle_control_fsm_if.master bus
);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             in_wait;
  logic             timeout;
  ctrl_t            ctrl;

  assign in_wait = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
  assign timeout = in_wait && !bus.mem_ready && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

  // Next-state selection; op only matters in DECODE and MEM_ADDR.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:       next_state = S_FETCH;
      S_FETCH:      next_state = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (bus.op == OP_LW)      next_state = S_MEM_READ;
        else if (bus.op == OP_SW) next_state = S_MEM_WRITE;
        else                      next_state = S_FETCH;
      end
      S_MEM_READ:   next_state = bus.mem_ready ? S_WRITE_BACK : S_MEM_READ;
      S_WRITE_BACK: next_state = S_FETCH;
      S_MEM_WRITE:  next_state = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:    next_state = S_R_COMPLETE;
      S_R_COMPLETE: next_state = S_FETCH;
      S_BRANCH:     next_state = S_FETCH;
      S_JUMP:       next_state = S_FETCH;
      default:      next_state = S_IDLE;
    endcase
    if (timeout) next_state = S_FETCH;
  end

  // State register and memory wait counter; the counter restarts on every
  // state change and after an abort so each wait gets a full budget.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (timeout || (next_state != state)) wait_cnt <= '0;
      else if (in_wait && !bus.mem_ready)   wait_cnt <= wait_cnt + 1'b1;
    end
  end

  multicycle_ctrl_decode u_decode (
    .state     (state),
    .mem_ready (bus.mem_ready),
    .op        (bus.op),
    .timeout   (timeout),
    .ctrl      (ctrl)
  );

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.illegal_op    = ctrl.illegal_op;
  assign bus.mem_timeout   = ctrl.mem_timeout;
  assign bus.state_dbg     = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - scoreboard bench for the multi-cycle control FSM
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm #(.TIMEOUT_CYCLES(15), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit         rst;
    logic [5:0] op;
    bit         rdy;
    int         st;
    bit         ill;
    bit         tmo;
  } step_t;

  step_t       steps[$];
  logic [22:0] sb[$];
  logic [22:0] exp_v;
  logic [22:0] got_v;
  int          vectors = 0;
  int          miscompares = 0;

  // Required controls as read off the state table:
  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
  //  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, mem_timeout}
  function automatic logic [18:0] exp_out(int st, bit rdy, bit ill, bit tmo);
    logic pcw, pcwc, iod, mr, mw, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pcw, pcwc, iod, mr, mw, irw, m2r, rdst, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    if (!tmo) begin
      case (st)
        1:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
        2:  asb = 2'b11;
        3:  begin asa = 1; asb = 2'b10; end
        4:  begin mr = 1; iod = 1; end
        5:  begin rw = 1; m2r = 1; end
        6:  begin mw = 1; iod = 1; end
        7:  begin asa = 1; aop = 2'b10; end
        8:  begin rw = 1; rdst = 1; end
        9:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
        10: begin pcw = 1; psrc = 2'b10; end
        default: ;
      endcase
    end
    return {pcw, pcwc, iod, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc, ill, tmo};
  endfunction

  function automatic logic [18:0] dut_out();
    return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal_op, bus.mem_timeout};
  endfunction

  task automatic add(bit rst, logic [5:0] op, bit rdy, int st, bit ill = 0, bit tmo = 0);
    step_t s;
    s.rst = rst; s.op = op; s.rdy = rdy; s.st = st; s.ill = ill; s.tmo = tmo;
    steps.push_back(s);
  endtask

  task automatic drive(step_t s);
    rst_n = s.rst;
    bus.op = s.op;
    bus.mem_ready = s.rdy;
    sb.push_back({4'(s.st), exp_out(s.st, s.rdy, s.ill, s.tmo)});
  endtask

  // Leaves the FSM in IDLE with rst_n released just after an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    bus.op = 6'b000000;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    steps.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.op = 6'b000000; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    steps.delete();
    for (int i = 0; i < 3; i++) add(0, 6'b000000, 1, 0);
    add(1, 6'b000000, 1, 0);
    add(1, 6'b000000, 1, 1);
    add(1, 6'b000000, 1, 2);
    add(1, 6'b100011, 1, 7);
    add(1, 6'b101011, 1, 8);
    add(1, 6'b000000, 0, 1);
    foreach (steps[i]) begin
      drive(steps[i]);
      @(negedge clk);
      exp_v = sb.pop_front();
      got_v = {bus.state_dbg, dut_out()};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL reset_rtype step %0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 i, got_v[22:19], got_v[18:0], exp_v[22:19], exp_v[18:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    do_reset();
    add(1, 6'b000000, 1, 0);
    add(1, 6'b000000, 1, 1);
    add(1, 6'b100011, 1, 2);
    add(1, 6'b100011, 1, 3);
    add(1, 6'b000000, 0, 4);
    add(1, 6'b000000, 0, 4);
    add(1, 6'b000000, 1, 4);
    add(1, 6'b000000, 1, 5);
    add(1, 6'b000000, 0, 1);
    foreach (steps[i]) begin
      drive(steps[i]);
      @(negedge clk);
      exp_v = sb.pop_front();
      got_v = {bus.state_dbg, dut_out()};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL lw_wait step %0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 i, got_v[22:19], got_v[18:0], exp_v[22:19], exp_v[18:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    add(1, 6'b000000, 1, 0);
    add(1, 6'b000000, 1, 1);
    add(1, 6'b101011, 1, 2);
    add(1, 6'b101011, 1, 3);
    add(1, 6'b000000, 1, 6);
    add(1, 6'b000000, 1, 1);
    add(1, 6'b000100, 1, 2);
    add(1, 6'b101011, 1, 9);
    add(1, 6'b000000, 0, 1);
    foreach (steps[i]) begin
      drive(steps[i]);
      @(negedge clk);
      exp_v = sb.pop_front();
      got_v = {bus.state_dbg, dut_out()};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL sw_beq step %0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 i, got_v[22:19], got_v[18:0], exp_v[22:19], exp_v[18:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    do_reset();
    add(1, 6'b000000, 1, 0);
    add(1, 6'b000000, 1, 1);
    add(1, 6'b111111, 1, 2, 1, 0);
    add(1, 6'b111111, 1, 1);
    add(1, 6'b000000, 0, 2);
    foreach (steps[i]) begin
      drive(steps[i]);
      @(negedge clk);
      exp_v = sb.pop_front();
      got_v = {bus.state_dbg, dut_out()};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL illegal_op step %0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 i, got_v[22:19], got_v[18:0], exp_v[22:19], exp_v[18:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  // late = 0: mem_ready stays low through the 16th FETCH cycle (abort).
  // late = 1: mem_ready rises on exactly that cycle (normal fetch wins).
  task automatic test_timeout(bit late);
    do_reset();
    add(1, 6'b000000, 1, 0);
    for (int k = 1; k <= 15; k++) add(1, 6'b000000, 0, 1);
    if (!late) begin
      add(1, 6'b000000, 0, 1, 0, 1);
      add(1, 6'b000000, 0, 1);
      add(1, 6'b000000, 1, 1);
      add(1, 6'b000010, 1, 2);
    end else begin
      add(1, 6'b000000, 1, 1);
      add(1, 6'b000010, 1, 2);
      add(1, 6'b000000, 1, 10);
    end
    foreach (steps[i]) begin
      drive(steps[i]);
      @(negedge clk);
      exp_v = sb.pop_front();
      got_v = {bus.state_dbg, dut_out()};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL timeout(late=%0d) step %0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 late, i, got_v[22:19], got_v[18:0], exp_v[22:19], exp_v[18:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    add(1, 6'b000000, 1, 0);
    add(1, 6'b000000, 1, 1);
    add(1, 6'b101011, 1, 2);
    add(1, 6'b101011, 1, 3);
    add(1, 6'b000000, 0, 6);
    add(0, 6'b000000, 0, 6);
    add(1, 6'b000000, 0, 0);
    add(1, 6'b000000, 1, 1);
    add(1, 6'b000010, 1, 2);
    add(1, 6'b000000, 1, 10);
    add(1, 6'b000000, 0, 1);
    foreach (steps[i]) begin
      drive(steps[i]);
      @(negedge clk);
      exp_v = sb.pop_front();
      got_v = {bus.state_dbg, dut_out()};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL reset_mid_sw step %0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 i, got_v[22:19], got_v[18:0], exp_v[22:19], exp_v[18:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus.op = 6'b000000;
    bus.mem_ready = 1'b1;
    test_reset();
    test_lw_wait();
    test_back_to_back();
    test_illegal();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_write();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
